uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller: bit/edge timing, checker strobes, frame accept
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      parity_enable,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [3:0]                bit_q, bit_d;
  logic                      par_en_q, par_en_d;
  logic                      par_flag_q, par_flag_d;
  logic                      samp_q, samp_d;
  logic                      strt_q, strt_d;
  logic                      deser_q, deser_d;
  logic                      par_q, par_d;
  logic                      stp_q, stp_d;
  logic                      dv_q, dv_d;

  logic                      presc_legal;
  logic                      at_last;
  logic [PRESCALE_WIDTH-1:0] strobe_edge;

  // Only oversampling ratios of 4, 8 and 16 are allowed to start a frame.
  assign presc_legal = (Prescale == PRESCALE_WIDTH'(4)) ||
                       (Prescale == PRESCALE_WIDTH'(8)) ||
                       (Prescale == PRESCALE_WIDTH'(16));

  // Last oversample of the current bit, using the ratio latched at frame start.
  assign at_last     = (edge_q == presc_q - PRESCALE_WIDTH'(1));
  // Strobes are registered, so they are decided from the next-cycle ratio and edge.
  assign strobe_edge = presc_d - PRESCALE_WIDTH'(2);

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_flag_d = par_flag_q;
    dv_d       = 1'b0;

    if (state_q == IDLE) begin
      edge_d = '0;
      bit_d  = '0;
      if (!RX_IN && presc_legal) begin
        state_d    = START;
        presc_d    = Prescale;
        par_en_d   = parity_enable;
        par_flag_d = 1'b0;
      end
    end else begin
      if (at_last) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + PRESCALE_WIDTH'(1);
      end

      case (state_q)
        START: begin
          if (at_last) begin
            state_d = strt_glitch ? IDLE : DATA;
          end
        end
        DATA: begin
          if (at_last && (bit_q == 4'(DATA_WIDTH))) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_last) begin
            par_flag_d = par_flag_q | par_err;
            state_d    = STOP;
          end
        end
        STOP: begin
          if (at_last) begin
            state_d = IDLE;
            dv_d    = ~stp_err & ~par_flag_q;
          end
        end
        default: state_d = IDLE;
      endcase

      // Any return to IDLE (normal end or aborted start) parks both counters at 0.
      if (state_d == IDLE) begin
        edge_d = '0;
        bit_d  = '0;
      end
    end

    samp_d  = (state_d != IDLE);
    strt_d  = (state_d == START)  && (edge_d == strobe_edge);
    deser_d = (state_d == DATA)   && (edge_d == strobe_edge);
    par_d   = (state_d == PARITY) && (edge_d == strobe_edge);
    stp_d   = (state_d == STOP)   && (edge_d == strobe_edge);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_flag_q <= 1'b0;
      samp_q     <= 1'b0;
      strt_q     <= 1'b0;
      deser_q    <= 1'b0;
      par_q      <= 1'b0;
      stp_q      <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_flag_q <= par_flag_d;
      samp_q     <= samp_d;
      strt_q     <= strt_d;
      deser_q    <= deser_d;
      par_q      <= par_d;
      stp_q      <= stp_d;
      dv_q       <= dv_d;
    end
  end

  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;
  assign dat_samp_en = samp_q;
  assign strt_chk_en = strt_q;
  assign deser_en    = deser_q;
  assign par_chk_en  = par_q;
  assign stp_chk_en  = stp_q;
  assign data_valid  = dv_q;

endmodule
